// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - programmable up/down iteration counter with start/busy/done handshake
// Optional back-to-back relaunch at the final iteration: define ITER_COUNTER_BACK2BACK_EN.
module iter_counter #(
  parameter int WIDTH = 6,
  parameter bit DOWN  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] final_idx;
  logic [WIDTH-1:0] start_val;
  logic             step;
  logic             launch;

  assign final_idx = DOWN ? '0 : term_q;
  assign start_val = DOWN ? term_val : '0;
  assign step      = (state == S_RUN) && en;

`ifdef ITER_COUNTER_BACK2BACK_EN
  logic restart_q;

  // A start on the final enabled edge, or during DONE, reloads immediately.
  assign launch = start && ((state == S_IDLE) || (state == S_DONE) || (step && last));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      restart_q <= 1'b0;
    end else if (clear) begin
      restart_q <= 1'b0;
    end else begin
      restart_q <= step && last && start;
    end
  end
`else
  assign launch = start && (state == S_IDLE);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (en && last) state_nxt = S_DONE;
      S_DONE: begin
`ifdef ITER_COUNTER_BACK2BACK_EN
        state_nxt = (restart_q || start) ? S_RUN : S_IDLE;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
    last = busy && (count == final_idx);
  end

  // The terminal check holds count at the final index, so no wrap occurs mid-run.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      term_q <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (launch) begin
      term_q <= term_val;
      count  <= start_val;
    end else if (step && !last) begin
      count <= DOWN ? (count - ONE) : (count + ONE);
    end
  end

endmodule

// File: doc/iter_counter.md
Name: iter_counter

Overview:
- Parametrised iteration counter for multdiv sequencing; generalises the fixed 6-bit free-running count.
- Adds programmable terminal value, up/down direction, stall enable and synchronous clear.
- Adds a start/busy/done handshake so the multiplier/divider control FSMs launch a run and get a single completion pulse instead of decoding raw count bits.

Parameters:
- WIDTH, 6, width of count and terminal value; max run length is 2^WIDTH enabled cycles.
- DOWN, 0, 0 = count up 0..term; 1 = count down term..0.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- clear  input  1  synchronous abort; returns the block to IDLE.
- start  input  1  launch request; sampled only in IDLE.
- en  input  1  advance enable; 0 stalls the count in RUN.
- term_val  input  WIDTH  terminal value, latched on accepted start.
- count  output  WIDTH  current iteration index.
- busy  output  1  high while in RUN.
- last  output  1  combinational: busy and count at final index (term for up, 0 for down).
- done  output  1  one-cycle pulse after the final enabled iteration.

Behaviour:
- Reset (reset=0, async): state IDLE, count=0, term register=0, busy=0, done=0. Release is synchronous to the next clock edge; no count change on the release edge unless start is sampled.
- States: IDLE, RUN, DONE (registered). busy and done are decoded from state: busy = RUN, done = DONE.
- IDLE + start=1:
  - latch term_val into term register;
  - load count (0 if DOWN=0, term_val if DOWN=1);
  - go to RUN next edge (busy=1 the cycle after start).
- IDLE + start=0: hold; count keeps its last value.
- RUN + en=0: hold all.
- RUN + en=1 + not last: count += 1 (up) or -= 1 (down).
- RUN + en=1 + last: go to DONE; count holds the final index.
- Run length: exactly term+1 enabled cycles. term=0 gives one enabled cycle, with last high on the first RUN cycle.
- DONE: lasts exactly one cycle (done=1, busy=0), then IDLE. start in DONE is ignored (see optional feature).
- start while in RUN is ignored. term_val changes after launch have no effect.
- clear=1 (sync): highest priority after reset.
  - next state IDLE, count=0, done=0;
  - overrides start and en in the same cycle.
- Arithmetic is modulo 2^WIDTH, but the terminal check stops the count before any wrap. term = 2^WIDTH-1 is legal and yields 2^WIDTH iterations.
- Latency: start edge -> first RUN cycle = 1 clock. Final enabled edge -> done = 1 clock.

Optional Feature:
- Macro: ITER_COUNTER_BACK2BACK_EN.
- Defined: in RUN with en=1, last=1 and start=1 on the same edge:
  - term register reloads from term_val and count reloads its start value;
  - state goes to DONE for one cycle with count already reloaded, then directly to RUN (not IDLE);
  - net effect: done pulses and the new run continues with one bubble cycle.
  - start during the DONE cycle is also accepted: it reloads and returns to RUN.
- Undefined: start is honoured only in IDLE; no reload path is present.

Test Plan:
- Reset mid-run: launch term=10, assert reset=0 at count=5 between clock edges -> count=0, busy=0, done=0 immediately (async); no done pulse after release.
- Up count, WIDTH=6, DOWN=0: start with term_val=5, en=1 continuously:
  - busy high for 6 cycles with count 0,1,2,3,4,5;
  - last high only at count=5;
  - done pulses once, 1 clock after that edge; then IDLE.
- Stall: term_val=3, en toggled 1,0,1,0,... -> count advances only on en=1 edges; done after exactly 4 enabled edges (8 clocks); start pulses while busy have no effect.
- Down count, DOWN=1: term_val=63 -> count runs 63..0 over 64 enabled cycles; last at count=0; done pulse; count reads 0 in IDLE.
- Boundaries:
  - term_val=0 -> one RUN cycle with last=1, then done;
  - term_val=63 (up) -> 64 iterations, no wrap to 0 during the run;
  - clear and start in the same cycle in IDLE -> stays IDLE, count=0.
- ITER_COUNTER_BACK2BACK_EN defined: term=2, hold start=1 at the last=1 edge with term_val=4:
  - done pulse;
  - busy resumes the following cycle;
  - second run counts 0..4;
  - total done pulses = 2.
- Same stimulus with the macro undefined: one done pulse only, block ends in IDLE.
